// File: rtl/conv1_pkg.sv
// Shared constants and types for the conv1 window generator.
// Image geometry and pixel width match the conv1 datapath.
package conv1_pkg;

  localparam int DATA_W = 32;
  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int KERNEL = 3;
  localparam int WIN_N  = KERNEL * KERNEL;

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(IMG_H);

  typedef logic [DATA_W-1:0] pixel_t;
  typedef pixel_t window_t [0:WIN_N-1];

endpackage

// File: rtl/conv1_line_buffer.sv
// One-row pixel delay line, circular, addressed by the column counter.
// Read is combinational so the old value is seen before the write lands.
module conv1_line_buffer
  import conv1_pkg::*;
#(
  parameter int DEPTH = IMG_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  pixel_t        din,
  output pixel_t        dout
);

  pixel_t mem_q [0:DEPTH-1];

  assign dout = mem_q[addr];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= din;
  end

endmodule

// File: rtl/conv1_window_gen.sv
// Streaming 3x3 window generator feeding conv1.
// Optional frame_done output: define CONV1_WINGEN_FRAME_DONE_EN.
module conv1_window_gen
  import conv1_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  pixel_t  pixel_in,
  input  logic    valid_in,
  input  logic    sof,
  output window_t data_out,
  output logic    valid_out
`ifdef CONV1_WINGEN_FRAME_DONE_EN
  ,
  output logic    frame_done
`endif
);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic [ROW_W-1:0] row_q, row_d, row_eff;
  window_t          win_q, win_d;
  logic             valid_q, valid_d;
  pixel_t           lb0_rd, lb1_rd;

  conv1_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk  (clk),
    .we   (valid_in),
    .addr (col_eff),
    .din  (pixel_in),
    .dout (lb0_rd)
  );

  conv1_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk  (clk),
    .we   (valid_in),
    .addr (col_eff),
    .din  (lb0_rd),
    .dout (lb1_rd)
  );

  // sof forces the accepted pixel to (0,0) whatever the counters say
  always_comb begin
    col_eff = (valid_in && sof) ? '0 : col_q;
    row_eff = (valid_in && sof) ? '0 : row_q;
  end

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    if (valid_in) begin
      for (int r = 0; r < KERNEL; r++) begin
        win_d[r*KERNEL]   = win_q[r*KERNEL+1];
        win_d[r*KERNEL+1] = win_q[r*KERNEL+2];
      end
      win_d[2] = lb1_rd;
      win_d[5] = lb0_rd;
      win_d[8] = pixel_in;
      valid_d  = (row_eff >= ROW_TWO) && (col_eff >= COL_TWO);
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      for (int i = 0; i < WIN_N; i++) win_q[i] <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      win_q   <= win_d;
    end
  end

  assign data_out  = win_q;
  assign valid_out = valid_q;

`ifdef CONV1_WINGEN_FRAME_DONE_EN
  logic fd_q, fd_d;

  always_comb begin
    fd_d = valid_in && (row_eff == ROW_LAST) && (col_eff == COL_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fd_q <= 1'b0;
    else        fd_q <= fd_d;
  end

  assign frame_done = fd_q;
`endif

endmodule

// File: tb/tb_conv1_window_gen.sv
// Scoreboard bench for conv1_window_gen; model windows from row*256+col.
// Frame-done scenario is built when CONV1_WINGEN_FRAME_DONE_EN is defined.
module tb_conv1_window_gen;
  import conv1_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  pixel_t  pixel_in = '0;
  logic    valid_in = 1'b0;
  logic    sof = 1'b0;
  window_t data_out;
  logic    valid_out;
`ifdef CONV1_WINGEN_FRAME_DONE_EN
  logic    frame_done;
`endif

  conv1_window_gen dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pixel_in  (pixel_in),
    .valid_in  (valid_in),
    .sof       (sof),
    .data_out  (data_out),
    .valid_out (valid_out)
`ifdef CONV1_WINGEN_FRAME_DONE_EN
    ,
    .frame_done(frame_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [8:0][31:0] w;
    logic             fd;
    int unsigned      due;
  } exp_t;

  exp_t             sbq[$];
  exp_t             mon_e;
  int unsigned      cyc = 0;
  int               passed = 0;
  int               total = 0;
  int               win_cnt = 0;
  int               fd_cnt = 0;
  bit               prev_v = 0;
  bit               b2b = 0;
  bit               ok;
  logic [8:0][31:0] first_w, last_w;
  int               mr = 0;
  int               mc = 0;

  // scoreboard monitor: one window per expected entry, exactly on its due cycle
  always @(posedge clk) begin
    cyc++;
    #1;
    if (valid_out) begin
      total++;
      if (sbq.size() == 0 || sbq[0].due != cyc) begin
        $display("FAIL unexpected_window cyc=%0d got[8]=%h", cyc, data_out[8]);
      end else begin
        mon_e = sbq.pop_front();
        ok = 1;
        for (int k = 0; k < 9; k++)
          if (data_out[k] !== mon_e.w[k]) ok = 0;
`ifdef CONV1_WINGEN_FRAME_DONE_EN
        if (frame_done !== mon_e.fd) ok = 0;
`endif
        if (ok) passed++;
        else $display("FAIL window cyc=%0d got[0]=%h [4]=%h [8]=%h exp[0]=%h [4]=%h [8]=%h",
                      cyc, data_out[0], data_out[4], data_out[8],
                      mon_e.w[0], mon_e.w[4], mon_e.w[8]);
      end
      for (int k = 0; k < 9; k++) begin
        if (win_cnt == 0) first_w[k] = data_out[k];
        last_w[k] = data_out[k];
      end
      win_cnt++;
      if (prev_v) b2b = 1;
    end else if (sbq.size() > 0 && sbq[0].due == cyc) begin
      total++;
      mon_e = sbq.pop_front();
      $display("FAIL missing_window cyc=%0d got valid=0 exp valid=1 exp[8]=%h",
               cyc, mon_e.w[8]);
    end
`ifdef CONV1_WINGEN_FRAME_DONE_EN
    if (frame_done) begin
      fd_cnt++;
      if (!valid_out) begin
        total++;
        $display("FAIL frame_done_alone cyc=%0d got valid=0 exp valid=1", cyc);
      end
    end
`endif
    prev_v = valid_out;
  end

  task automatic send(input bit s);
    exp_t e;
    @(negedge clk);
    if (s) begin
      mr = 0;
      mc = 0;
    end
    valid_in = 1'b1;
    sof      = s;
    pixel_in = pixel_t'(mr * 256 + mc);
    if (mr >= 2 && mc >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[i*3+j] = 32'((mr - 2 + i) * 256 + (mc - 2 + j));
      e.fd  = (mr == IMG_H - 1) && (mc == IMG_W - 1);
      e.due = cyc + 1;
      sbq.push_back(e);
    end
    if (mc == IMG_W - 1) begin
      mc = 0;
      mr = (mr == IMG_H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      valid_in = 1'b0;
      sof      = 1'b0;
    end
  endtask

  task automatic send_until(input int r, input int c);
    while (!(mr == r && mc == c)) send(1'b0);
  endtask

  task automatic test_reset;
    repeat (2) begin
      @(negedge clk);
      total++;
      ok = (valid_out === 1'b0);
      for (int k = 0; k < 9; k++) if (data_out[k] !== '0) ok = 0;
      if (ok) passed++;
      else $display("FAIL reset_state got valid=%b d0=%h exp valid=0 d0=0",
                    valid_out, data_out[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
  endtask

  task automatic check_frame(input string nm);
    total++;
    if (win_cnt === 676) passed++;
    else $display("FAIL %s_count got %0d exp 676", nm, win_cnt);
    total++;
    if (first_w[0] === 32'h0 && first_w[4] === 32'h101 && first_w[8] === 32'h202) passed++;
    else $display("FAIL %s_first got %h/%h/%h exp 0/101/202",
                  nm, first_w[0], first_w[4], first_w[8]);
    total++;
    if (last_w[8] === 32'h1B1B) passed++;
    else $display("FAIL %s_last got %h exp 1b1b", nm, last_w[8]);
    total++;
    if (sbq.size() == 0) passed++;
    else $display("FAIL %s_drain got %0d pending exp 0", nm, sbq.size());
  endtask

  task automatic test_full_frame;
    win_cnt = 0;
    repeat (IMG_W * IMG_H) send(1'b0);
    idle(3);
    check_frame("full");
  endtask

  task automatic test_row_boundary;
    send(1'b1);
    send_until(3, 0);
    for (int c = 0; c < 2; c++) begin
      send(1'b0);
      @(posedge clk);
      #2;
      total++;
      if (valid_out === 1'b0) passed++;
      else $display("FAIL row_wrap_c%0d got valid=1 exp valid=0", c);
    end
    send(1'b0);
    @(posedge clk);
    #2;
    total++;
    if (valid_out === 1'b1 && data_out[0] === 32'h100 && data_out[2] === 32'h102 &&
        data_out[6] === 32'h300 && data_out[8] === 32'h302) passed++;
    else $display("FAIL row_3_2 got v=%b %h/%h/%h/%h exp 1 100/102/300/302",
                  valid_out, data_out[0], data_out[2], data_out[6], data_out[8]);
    idle(2);
  endtask

  task automatic test_gapped;
    win_cnt = 0;
    b2b = 0;
    send(1'b1);
    idle(1);
    repeat (IMG_W * IMG_H - 1) begin
      send(1'b0);
      idle(1);
    end
    idle(3);
    check_frame("gapped");
    total++;
    if (b2b == 0) passed++;
    else $display("FAIL gapped_b2b got 1 exp 0");
  endtask

  task automatic test_sof_mid;
    int cnt0;
    send(1'b1);
    send_until(10, 5);
    send(1'b1);
    @(posedge clk);
    #2;
    cnt0 = win_cnt;
    send_until(2, 2);
    @(posedge clk);
    #2;
    total++;
    if (win_cnt == cnt0) passed++;
    else $display("FAIL sof_quiet got %0d windows exp 0", win_cnt - cnt0);
    send(1'b0);
    @(posedge clk);
    #2;
    total++;
    if (valid_out === 1'b1 && data_out[0] === 32'h0 && data_out[8] === 32'h202) passed++;
    else $display("FAIL sof_first got v=%b %h/%h exp 1 0/202",
                  valid_out, data_out[0], data_out[8]);
    idle(2);
  endtask

  task automatic test_reset_mid;
    send(1'b1);
    send_until(15, 15);
    send(1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #2;
      total++;
      ok = (valid_out === 1'b0);
      for (int k = 0; k < 9; k++) if (data_out[k] !== '0) ok = 0;
      if (ok) passed++;
      else $display("FAIL mid_reset got valid=%b d8=%h exp 0/0", valid_out, data_out[8]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mr = 0;
    mc = 0;
    test_full_frame();
  endtask

`ifdef CONV1_WINGEN_FRAME_DONE_EN
  task automatic test_frame_done;
    fd_cnt = 0;
    send(1'b1);
    repeat (2 * IMG_W * IMG_H - 1) send(1'b0);
    idle(3);
    total++;
    if (fd_cnt == 2) passed++;
    else $display("FAIL frame_done_count got %0d exp 2", fd_cnt);
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_row_boundary();
    test_gapped();
    test_sof_mid();
    test_reset_mid();
`ifdef CONV1_WINGEN_FRAME_DONE_EN
    test_frame_done();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got no finish exp finish");
    $fatal(1, "timeout");
  end

endmodule
